// File: rtl/lot_gate_controller.sv
// lot_gate_controller
//
// Sequences a two-gate parking lot (entry and exit) in front of an occupancy
// counter. Only one gate is open at a time. Each car is tracked through its
// gate's pass-through sensor, and every completed passage produces exactly
// one single-cycle inc (entry) or dec (exit) pulse. Entry is refused while
// the counter reports full.
//
// Configuration macro:
//   EXIT_PRIORITY_EN - when defined, a tie between effective entry and exit
//                      requests always goes to exit. When undefined, ties
//                      alternate between the two gates (round-robin).
//
// Parameters:
//   TIMEOUT - cycles a gate stays open waiting for a car (1..65535)
//   TW      - timer width, 2**TW > TIMEOUT
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   entry_req    level request from the entry gate
//   exit_req     level request from the exit gate
//   entry_sense  entry pass-through sensor (high while a car is in the gate)
//   exit_sense   exit pass-through sensor
//   full         lot-full flag from the counter
//   entry_open   entry gate actuator (registered)
//   exit_open    exit gate actuator (registered)
//   inc          one-cycle pulse, car entered
//   dec          one-cycle pulse, car exited
//   denied       one-cycle pulse, entry refused because full
//   timeout      one-cycle pulse, open gate aborted with no car
//   busy         high whenever the controller is not idle
module lot_gate_controller #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TW      = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic entry_req,
    input  logic exit_req,
    input  logic entry_sense,
    input  logic exit_sense,
    input  logic full,
    output logic entry_open,
    output logic exit_open,
    output logic inc,
    output logic dec,
    output logic denied,
    output logic timeout,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EN_OPEN = 3'd1,
        EN_PASS = 3'd2,
        EN_DONE = 3'd3,
        EX_OPEN = 3'd4,
        EX_PASS = 3'd5,
        EX_DONE = 3'd6
    } state_t;

    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

    state_t        state_r;
    logic [TW-1:0] timer_r;
    logic          eff_entry_s;
    logic          grant_entry_s;
    logic          grant_exit_s;

`ifdef EXIT_PRIORITY_EN
    // Arbitration: exit always wins a tie so a space is freed first.
    always_comb begin
        eff_entry_s   = entry_req & ~full;
        grant_exit_s  = exit_req;
        grant_entry_s = eff_entry_s & ~exit_req;
    end
`else
    // 1'b1 means the most recent grant went to the exit gate.
    logic last_grant_r;

    // Arbitration: a tie goes to the gate opposite the most recent grant.
    always_comb begin
        eff_entry_s   = entry_req & ~full;
        grant_entry_s = 1'b0;
        grant_exit_s  = 1'b0;
        if (eff_entry_s && exit_req) begin
            grant_entry_s = last_grant_r;
            grant_exit_s  = ~last_grant_r;
        end else begin
            grant_entry_s = eff_entry_s;
            grant_exit_s  = exit_req;
        end
    end
`endif

    // Gate sequencing FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            timer_r      <= '0;
`ifndef EXIT_PRIORITY_EN
            last_grant_r <= 1'b1;
`endif
            entry_open   <= 1'b0;
            exit_open    <= 1'b0;
            inc          <= 1'b0;
            dec          <= 1'b0;
            denied       <= 1'b0;
            timeout      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            // Pulse outputs are single-cycle unless re-asserted below.
            inc     <= 1'b0;
            dec     <= 1'b0;
            denied  <= 1'b0;
            timeout <= 1'b0;
            case (state_r)
                IDLE: begin
                    // Refusal is reported even when exit is granted this cycle.
                    denied  <= entry_req & full;
                    timer_r <= '0;
                    if (grant_entry_s) begin
                        state_r      <= EN_OPEN;
                        entry_open   <= 1'b1;
                        exit_open    <= 1'b0;
                        busy         <= 1'b1;
`ifndef EXIT_PRIORITY_EN
                        last_grant_r <= 1'b0;
`endif
                    end else if (grant_exit_s) begin
                        state_r      <= EX_OPEN;
                        entry_open   <= 1'b0;
                        exit_open    <= 1'b1;
                        busy         <= 1'b1;
`ifndef EXIT_PRIORITY_EN
                        last_grant_r <= 1'b1;
`endif
                    end else begin
                        state_r    <= IDLE;
                        entry_open <= 1'b0;
                        exit_open  <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                EN_OPEN, EX_OPEN: begin
                    // A sensor hit beats a coincident expiry.
                    if ((state_r == EN_OPEN) ? entry_sense : exit_sense) begin
                        state_r <= (state_r == EN_OPEN) ? EN_PASS : EX_PASS;
                    end else if (timer_r == TIMEOUT_LAST) begin
                        state_r    <= IDLE;
                        timer_r    <= '0;
                        entry_open <= 1'b0;
                        exit_open  <= 1'b0;
                        busy       <= 1'b0;
                        timeout    <= 1'b1;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                EN_PASS: begin
                    // Car has cleared the sensor: close and count it.
                    if (!entry_sense) begin
                        state_r    <= EN_DONE;
                        entry_open <= 1'b0;
                        inc        <= 1'b1;
                    end else begin
                        state_r <= EN_PASS;
                    end
                end
                EX_PASS: begin
                    if (!exit_sense) begin
                        state_r   <= EX_DONE;
                        exit_open <= 1'b0;
                        dec       <= 1'b1;
                    end else begin
                        state_r <= EX_PASS;
                    end
                end
                EN_DONE, EX_DONE: begin
                    // Gives the counter a cycle to update full before arbitration.
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    timer_r    <= '0;
                    entry_open <= 1'b0;
                    exit_open  <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lot_gate_controller.sv
module tb_lot_gate_controller;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic entry_req = 1'b0, exit_req = 1'b0;
    logic entry_sense = 1'b0, exit_sense = 1'b0, full = 1'b0;
    logic entry_open, exit_open, inc, dec, denied, timeout, busy;

    int total = 0;
    int bad = 0;
    bit started = 1'b0;

    lot_gate_controller #(.TIMEOUT(TO), .TW(16)) dut (
        .clk(clk), .reset(reset),
        .entry_req(entry_req), .exit_req(exit_req),
        .entry_sense(entry_sense), .exit_sense(exit_sense), .full(full),
        .entry_open(entry_open), .exit_open(exit_open),
        .inc(inc), .dec(dec), .denied(denied), .timeout(timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_gate: 0 none open, 1 entry open, 2 exit open
    int m_gate, m_wait;
    bit m_car, m_cool, m_last_exit;
    bit e_inc, e_dec, e_den, e_to;

    task automatic model_reset();
        m_gate = 0; m_wait = 0; m_car = 0; m_cool = 0; m_last_exit = 1;
        e_inc = 0; e_dec = 0; e_den = 0; e_to = 0;
    endtask

    task automatic model_step();
        bit want_en, want_ex, s;
        int pick;
        e_inc = 0; e_dec = 0; e_den = 0; e_to = 0;
        if (m_cool) begin
            m_cool = 0;
        end else if (m_gate == 0) begin
            want_en = entry_req && !full;
            want_ex = exit_req;
            e_den = entry_req && full;
            if (want_en && want_ex) begin
`ifdef EXIT_PRIORITY_EN
                pick = 2;
`else
                pick = m_last_exit ? 1 : 2;
`endif
            end else if (want_en) pick = 1;
            else if (want_ex) pick = 2;
            else pick = 0;
            if (pick != 0) begin
                m_gate = pick; m_last_exit = (pick == 2); m_wait = 0; m_car = 0;
            end
        end else begin
            s = (m_gate == 1) ? entry_sense : exit_sense;
            if (!m_car) begin
                if (s) m_car = 1;
                else if (m_wait == TO - 1) begin m_gate = 0; e_to = 1; end
                else m_wait++;
            end else if (!s) begin
                if (m_gate == 1) e_inc = 1; else e_dec = 1;
                m_gate = 0; m_cool = 1;
            end
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else model_step();
    end

    // Per-cycle comparison of every output against the model.
    always @(posedge clk) begin
        #1;
        if (started) begin
            chk("m_entry_open", entry_open, (m_gate == 1));
            chk("m_exit_open", exit_open, (m_gate == 2));
            chk("m_busy", busy, (m_gate != 0 || m_cool));
            chk("m_inc", inc, e_inc);
            chk("m_dec", dec, e_dec);
            chk("m_denied", denied, e_den);
            chk("m_timeout", timeout, e_to);
            chk("m_excl_open", (entry_open & exit_open), 0);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        entry_req = 0; exit_req = 0; entry_sense = 0; exit_sense = 0; full = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin : stim
        int n_open, n_to, n_inc, n_den, n_busy, w;
        int order [4];
        int exp_order [4];
        #1 reset = 1'b1;
        started = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_outputs", {entry_open, exit_open, inc, dec, denied, timeout, busy}, 0);
        reset = 1'b0;

        // 1: single entry passage
        @(negedge clk); entry_req = 1;
        @(negedge clk); chk("t1_open_next", entry_open, 1);
        entry_req = 0; entry_sense = 1;
        repeat (3) @(negedge clk);
        entry_sense = 0;
        @(negedge clk);
        chk("t1_inc", inc, 1); chk("t1_closed_on_inc", entry_open, 0);
        @(negedge clk);
        chk("t1_inc_once", inc, 0); chk("t1_idle", busy, 0);

        // 2: timeout, no car
        do_reset();
        @(negedge clk); entry_req = 1;
        n_open = 0; n_to = 0; n_inc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) entry_req = 0;
            n_open += entry_open; n_to += timeout; n_inc += inc;
        end
        chk("t2_open_cycles", n_open, TO);
        chk("t2_timeout_cnt", n_to, 1);
        chk("t2_no_inc", n_inc, 0);

        // 3: full refuses entry
        do_reset();
        @(negedge clk); full = 1; entry_req = 1;
        n_den = 0; n_open = 0; n_busy = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) entry_req = 0;
            n_den += denied; n_open += entry_open; n_busy += busy;
        end
        chk("t3_denied_cnt", n_den, 3);
        chk("t3_never_open", n_open, 0);
        chk("t3_never_busy", n_busy, 0);
        full = 0;

        // 4: tie arbitration order over four passages
        do_reset();
        @(negedge clk); entry_req = 1; exit_req = 1;
`ifdef EXIT_PRIORITY_EN
        exp_order = '{2, 2, 2, 2};
`else
        exp_order = '{1, 2, 1, 2};
`endif
        for (int k = 0; k < 4; k++) begin
            w = 0;
            while (!(entry_open || exit_open) && w < 10) begin @(negedge clk); w++; end
            order[k] = entry_open ? 1 : (exit_open ? 2 : 0);
            if (entry_open) entry_sense = 1; else exit_sense = 1;
            @(negedge clk);
            entry_sense = 0; exit_sense = 0;
            repeat (2) @(negedge clk);
        end
        for (int k = 0; k < 4; k++) chk($sformatf("t4_order%0d", k), order[k], exp_order[k]);
        entry_req = 0; exit_req = 0;

        // 5: full with both requests -> exit granted, denied same cycle
        do_reset();
        @(negedge clk); full = 1; entry_req = 1; exit_req = 1;
        @(negedge clk);
        chk("t5_exit_granted", exit_open, 1); chk("t5_denied", denied, 1);
        exit_req = 0; exit_sense = 1;
        @(negedge clk); exit_sense = 0;
        @(negedge clk); chk("t5_dec", dec, 1); full = 0;
        @(negedge clk);
        @(negedge clk); chk("t5_entry_next", entry_open, 1);
        entry_req = 0;

        // 6: async reset mid exit passage
        do_reset();
        @(negedge clk); exit_req = 1;
        @(negedge clk); exit_req = 0; exit_sense = 1;
        @(negedge clk); chk("t6_exit_open_pre", exit_open, 1);
        #2 reset = 1'b1;
        #1 chk("t6_async_close", exit_open, 0); chk("t6_no_dec", dec, 0); chk("t6_not_busy", busy, 0);
        @(negedge clk); exit_sense = 0;
        @(negedge clk); reset = 1'b0;
        @(negedge clk); entry_req = 1; exit_req = 1;
        @(negedge clk);
`ifdef EXIT_PRIORITY_EN
        chk("t6_tie_after_reset", {entry_open, exit_open}, 2'b01);
`else
        chk("t6_tie_after_reset", {entry_open, exit_open}, 2'b10);
`endif
        entry_req = 0; exit_req = 0;
        repeat (TO + 4) @(negedge clk);

        started = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
